stopwatch_bcd: RTL
==================

STOPWATCH_BCD -- requirements
Module: stopwatch_bcd

Interface
REQ-001 SHALL provide parameter SYNC_STAGES, default 2, number of synchronizer flops on tick_in (minimum 2).
REQ-002 SHALL provide port clock_in, input, 1, the single system clock; all state changes on its rising edge.
REQ-003 SHALL provide port rst_n, input, 1; reset is asynchronous and active-low.
REQ-004 SHALL provide port tick_in, input, 1, divided timebase level from the upstream divider; each rising edge equals 0.1 s.
REQ-005 SHALL provide port start_stop, input, 1, one-clock command pulse that toggles run/pause.
REQ-006 SHALL provide port clear, input, 1, one-clock command pulse that zeroes the count.
REQ-007 SHALL provide port lap, input, 1, one-clock command pulse that freezes or releases the display.
REQ-008 SHALL provide port disp_tenth, output, 4, displayed tenths digit in BCD (0-9).
REQ-009 SHALL provide port disp_sec_lo, output, 4, displayed seconds-units digit in BCD (0-9).
REQ-010 SHALL provide port disp_sec_hi, output, 4, displayed seconds-tens digit in BCD (0-5).
REQ-011 SHALL provide port disp_min_lo, output, 4, displayed minutes-units digit in BCD (0-9).
REQ-012 SHALL provide port disp_min_hi, output, 4, displayed minutes-tens digit in BCD (0-5).
REQ-013 SHALL provide port running, output, 1, high in RUN and LAP.
REQ-014 SHALL provide port lap_active, output, 1, high in LAP.
REQ-015 SHALL provide port overflow, output, 1, one-clock pulse on wrap from 59:59.9.

Function
REQ-016 SHALL pass tick_in through SYNC_STAGES flops plus one history flop, forming tick_pulse = sync_out AND NOT history.
REQ-017 SHALL increment the live count on the clock after tick_pulse, only in RUN or LAP; with SYNC_STAGES=2 the live count changes at the 3rd clock_in edge after tick_in is first sampled high.
REQ-018 SHALL implement a cascaded BCD counter (tenths 0-9, sec_lo 0-9, sec_hi 0-5, min_lo 0-9, min_hi 0-5), each digit advancing only when all lower digits are at their maximum.
REQ-019 SHALL wrap 59:59.9 to 00:00.0 and assert overflow for exactly that one clock.
REQ-020 SHALL implement FSM states IDLE, RUN, PAUSE and LAP.
REQ-021 SHALL apply these FSM transitions:
- IDLE + start_stop -> RUN
- RUN + start_stop -> PAUSE
- PAUSE + start_stop -> RUN
- RUN + lap -> LAP, capturing a snapshot of the live count
- LAP + lap -> RUN
- LAP + start_stop -> PAUSE
REQ-022 SHALL ignore lap in IDLE and PAUSE.
REQ-023 SHALL, on clear in any state, zero the live count and snapshot and go to IDLE; clear beats start_stop, lap and a coincident tick_pulse.
REQ-024 SHALL, when start_stop and lap arrive together without clear, apply start_stop and drop lap.
REQ-025 SHALL drive the disp_* outputs from the snapshot in LAP and from the live count in all other states, registered one clock after selection.
REQ-026 SHALL, when tick_pulse coincides with the RUN->LAP capture, store the pre-increment value in the snapshot.
REQ-027 SHALL never drive a BCD digit output above its maximum.

Reset
REQ-028 SHALL, while rst_n is low, force FSM=IDLE, all digits, snapshot and disp_* = 0, running=0, lap_active=0, overflow=0, and all synchronizer and history flops = 0.
REQ-029 SHALL take effect immediately on rst_n asserting, including mid-count, with release synchronous to clock_in.

Structure
REQ-030 SHALL place the state enum and the digit maxima (9, 5) in shared package stopwatch_pkg.
REQ-031 SHALL build the counter from five instances of sub-module bcd_digit (parameter MAX; inputs inc, clr; outputs value, carry).

Verification
REQ-032 SHALL cover: reset, start_stop, 10 tick_in rising edges -> display 00:01.0, running=1.
REQ-033 SHALL cover: preload to 59:59.8, 2 ticks in RUN -> 00:00.0, overflow high for exactly one clock.
REQ-034 SHALL cover: RUN at 00:03.4, lap, 5 ticks -> display holds 00:03.4; lap again -> display 00:03.9.
REQ-035 SHALL cover: clear coincident with tick_pulse and start_stop in RUN -> IDLE, display 00:00.0, running=0.
REQ-036 SHALL cover: PAUSE at 00:07.2, 4 ticks -> display unchanged; start_stop, 1 tick -> 00:07.3.
REQ-037 SHALL cover: rst_n low mid-RUN at 12:34.5 -> all outputs 0 immediately, with no clock required.

Source files
------------

// File: rtl/stopwatch_pkg.sv
// Shared types and constants for the BCD stopwatch: FSM states, digit maxima
// and the packed five-digit time value.
package stopwatch_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2,
        ST_LAP   = 2'd3
    } state_t;

    localparam logic [3:0] DIGIT_MAX_DEC = 4'd9;
    localparam logic [3:0] DIGIT_MAX_SEX = 4'd5;

    typedef struct packed {
        logic [3:0] min_hi;
        logic [3:0] min_lo;
        logic [3:0] sec_hi;
        logic [3:0] sec_lo;
        logic [3:0] tenth;
    } bcd_time_t;

endpackage

// File: rtl/bcd_digit.sv
// One BCD digit of the cascaded counter: counts 0..MAX on inc, clears on clr,
// and flags carry when an increment wraps it back to zero.
module bcd_digit
    import stopwatch_pkg::*;
#(
    parameter logic [3:0] MAX = DIGIT_MAX_DEC
) (
    input  logic       clock_in,
    input  logic       rst_n,
    input  logic       inc,
    input  logic       clr,
    output logic [3:0] value,
    output logic       carry
);

    logic [3:0] r_value;

    // clr outranks inc; any out-of-range value wraps to zero on the next increment
    always_ff @(posedge clock_in or negedge rst_n) begin
        if (!rst_n) begin
            r_value <= '0;
        end else if (clr) begin
            r_value <= '0;
        end else if (inc) begin
            r_value <= (r_value >= MAX) ? 4'd0 : r_value + 4'd1;
        end
    end

    assign value = r_value;
    assign carry = inc && (r_value >= MAX);

endmodule

// File: rtl/stopwatch_bcd.sv
// MM:SS.t stopwatch: synchronised tick edge detector, five cascaded BCD digits,
// run/pause/lap FSM with snapshot, and a registered display mux.
module stopwatch_bcd
    import stopwatch_pkg::*;
#(
    parameter int SYNC_STAGES = 2  // must be at least 2
) (
    input  logic       clock_in,
    input  logic       rst_n,
    input  logic       tick_in,
    input  logic       start_stop,
    input  logic       clear,
    input  logic       lap,
    output logic [3:0] disp_tenth,
    output logic [3:0] disp_sec_lo,
    output logic [3:0] disp_sec_hi,
    output logic [3:0] disp_min_lo,
    output logic [3:0] disp_min_hi,
    output logic       running,
    output logic       lap_active,
    output logic       overflow
);

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_tick_hist;
    state_t                 r_state;
    logic                   r_running;
    logic                   r_lap_active;
    logic                   r_overflow;
    bcd_time_t              r_snap;
    bcd_time_t              r_disp;

    logic                   w_tick_pulse;
    logic                   w_count_en;
    logic [4:0]             w_inc;
    logic [4:0]             w_carry;
    bcd_time_t              w_live;

    always_ff @(posedge clock_in or negedge rst_n) begin
        if (!rst_n) begin
            r_sync      <= '0;
            r_tick_hist <= 1'b0;
        end else begin
            r_sync      <= {r_sync[SYNC_STAGES-2:0], tick_in};
            r_tick_hist <= r_sync[SYNC_STAGES-1];
        end
    end

    assign w_tick_pulse = r_sync[SYNC_STAGES-1] & ~r_tick_hist;
    assign w_count_en   = (r_state == ST_RUN) || (r_state == ST_LAP);

    // Each digit advances only on the carry of the one below it
    assign w_inc[0] = w_count_en & w_tick_pulse;
    assign w_inc[1] = w_carry[0];
    assign w_inc[2] = w_carry[1];
    assign w_inc[3] = w_carry[2];
    assign w_inc[4] = w_carry[3];

    bcd_digit #(.MAX(DIGIT_MAX_DEC)) u_tenth (
        .clock_in (clock_in), .rst_n (rst_n), .inc (w_inc[0]), .clr (clear),
        .value    (w_live.tenth), .carry (w_carry[0])
    );
    bcd_digit #(.MAX(DIGIT_MAX_DEC)) u_sec_lo (
        .clock_in (clock_in), .rst_n (rst_n), .inc (w_inc[1]), .clr (clear),
        .value    (w_live.sec_lo), .carry (w_carry[1])
    );
    bcd_digit #(.MAX(DIGIT_MAX_SEX)) u_sec_hi (
        .clock_in (clock_in), .rst_n (rst_n), .inc (w_inc[2]), .clr (clear),
        .value    (w_live.sec_hi), .carry (w_carry[2])
    );
    bcd_digit #(.MAX(DIGIT_MAX_DEC)) u_min_lo (
        .clock_in (clock_in), .rst_n (rst_n), .inc (w_inc[3]), .clr (clear),
        .value    (w_live.min_lo), .carry (w_carry[3])
    );
    bcd_digit #(.MAX(DIGIT_MAX_SEX)) u_min_hi (
        .clock_in (clock_in), .rst_n (rst_n), .inc (w_inc[4]), .clr (clear),
        .value    (w_live.min_hi), .carry (w_carry[4])
    );

    // start_stop is tested before lap in every state, so a coincident lap is dropped
    always_ff @(posedge clock_in or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= ST_IDLE;
            r_running    <= 1'b0;
            r_lap_active <= 1'b0;
            r_snap       <= '0;
        end else if (clear) begin
            r_state      <= ST_IDLE;
            r_running    <= 1'b0;
            r_lap_active <= 1'b0;
            r_snap       <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (start_stop) begin
                        r_state   <= ST_RUN;
                        r_running <= 1'b1;
                    end
                end
                ST_RUN: begin
                    if (start_stop) begin
                        r_state   <= ST_PAUSE;
                        r_running <= 1'b0;
                    end else if (lap) begin
                        r_state      <= ST_LAP;
                        r_lap_active <= 1'b1;
                        r_snap       <= w_live;  // pre-increment value if a tick lands now
                    end
                end
                ST_PAUSE: begin
                    if (start_stop) begin
                        r_state   <= ST_RUN;
                        r_running <= 1'b1;
                    end
                end
                ST_LAP: begin
                    if (start_stop) begin
                        r_state      <= ST_PAUSE;
                        r_running    <= 1'b0;
                        r_lap_active <= 1'b0;
                    end else if (lap) begin
                        r_state      <= ST_RUN;
                        r_lap_active <= 1'b0;
                    end
                end
                default: begin
                    r_state      <= ST_IDLE;
                    r_running    <= 1'b0;
                    r_lap_active <= 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clock_in or negedge rst_n) begin
        if (!rst_n) begin
            r_overflow <= 1'b0;
            r_disp     <= '0;
        end else begin
            r_overflow <= w_carry[4] & ~clear;
            r_disp     <= (r_state == ST_LAP) ? r_snap : w_live;
        end
    end

    assign disp_tenth  = r_disp.tenth;
    assign disp_sec_lo = r_disp.sec_lo;
    assign disp_sec_hi = r_disp.sec_hi;
    assign disp_min_lo = r_disp.min_lo;
    assign disp_min_hi = r_disp.min_hi;
    assign running     = r_running;
    assign lap_active  = r_lap_active;
    assign overflow    = r_overflow;

endmodule
